// File: rtl/seg7_scan4.sv
// rtl/seg7_scan4.sv - four-digit multiplexed 7-segment scanner with frame-synchronous double buffering
// Optional feature macro: SEG7_SCAN_BLANK_EN (per-slot anti-ghosting dead time of BLANK_CYC cycles)

module seg7_scan4 #(
    parameter logic [15:0] PRESCALE  = 16'd49999,
    parameter logic [15:0] BLANK_CYC = 16'd4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        load,
    input  logic [31:0] seg_in,
    output logic [7:0]  seg,
    output logic [3:0]  an,
    output logic        frame
);

    // ST_IDLE: display blanked, counters parked at digit 0 / pcnt 0.
    // ST_SCAN: counters running. The first enabled edge leaves pcnt at 0 so
    // digit 0 of a restarted scan gets a full PRESCALE+1 cycles on the pins.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [15:0]     pcnt;
    logic [15:0]     pcnt_nxt;
    logic [1:0]      idx;
    logic [1:0]      idx_nxt;
    logic [3:0][7:0] disp;
    logic [3:0][7:0] disp_nxt;
    logic [3:0][7:0] pend;
    logic [3:0][7:0] pend_nxt;
    logic            pflag;
    logic            pflag_nxt;
    logic [7:0]      seg_nxt;
    logic [3:0]      an_nxt;
    logic            frame_nxt;
    logic            tick;
    logic            wrap;

    assign tick = (state == ST_SCAN) && (pcnt == PRESCALE);
    assign wrap = tick && (idx == 2'd3);

`ifndef SEG7_SCAN_BLANK_EN
    // Dead time is compiled out; this only keeps the parameter referenced.
    logic unused_blank_cyc;
    assign unused_blank_cyc = ^BLANK_CYC;
`endif

    // Next-state logic: scan counters, buffer transfer and registered output values.
    always_comb begin
        state_nxt = state;
        pcnt_nxt  = pcnt;
        idx_nxt   = idx;
        disp_nxt  = disp;
        pend_nxt  = pend;
        pflag_nxt = pflag;
        seg_nxt   = 8'h00;
        an_nxt    = 4'b1111;
        frame_nxt = 1'b0;

        if (!en) begin
            // Display is dark, so a load can go straight to the display regs.
            state_nxt = ST_IDLE;
            pcnt_nxt  = 16'd0;
            idx_nxt   = 2'd0;
            if (load) begin
                disp_nxt  = seg_in;
                pflag_nxt = 1'b0;
            end
        end else begin
            if (state == ST_IDLE) begin
                state_nxt = ST_SCAN;
                pcnt_nxt  = 16'd0;
                idx_nxt   = 2'd0;
            end else if (tick) begin
                pcnt_nxt = 16'd0;
                idx_nxt  = idx + 2'd1;
            end else begin
                pcnt_nxt = pcnt + 16'd1;
            end

            if (wrap) begin
                // Frame boundary: the only point where the visible set changes.
                frame_nxt = 1'b1;
                if (load) begin
                    disp_nxt  = seg_in;
                    pflag_nxt = 1'b0;
                end else if (pflag) begin
                    disp_nxt  = pend;
                    pflag_nxt = 1'b0;
                end
            end else if (load) begin
                pend_nxt  = seg_in;
                pflag_nxt = 1'b1;
            end

            // Outputs follow the post-edge digit and buffer with no extra lag.
            seg_nxt = disp_nxt[idx_nxt];
            an_nxt  = ~(4'b0001 << idx_nxt);

`ifdef SEG7_SCAN_BLANK_EN
            if (pcnt_nxt < BLANK_CYC) begin
                seg_nxt = 8'h00;
                an_nxt  = 4'b1111;
            end
`endif
        end
    end

    // State and output registers; reset blanks the display immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            pcnt  <= 16'd0;
            idx   <= 2'd0;
            disp  <= '0;
            pend  <= '0;
            pflag <= 1'b0;
            seg   <= 8'h00;
            an    <= 4'b1111;
            frame <= 1'b0;
        end else begin
            state <= state_nxt;
            pcnt  <= pcnt_nxt;
            idx   <= idx_nxt;
            disp  <= disp_nxt;
            pend  <= pend_nxt;
            pflag <= pflag_nxt;
            seg   <= seg_nxt;
            an    <= an_nxt;
            frame <= frame_nxt;
        end
    end

endmodule

// File: tb/tb_seg7_scan4.sv
// tb/tb_seg7_scan4.sv - self-checking bench for seg7_scan4 with a time-based reference model

module tb_seg7_scan4;

    localparam logic [15:0] PS   = 16'd3;
    localparam logic [15:0] BC   = 16'd1;
    localparam int          SLOT = 4;
    localparam int          FRM  = 4 * SLOT;
    localparam int          BLK  = 1;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic        en     = 1'b0;
    logic        load   = 1'b0;
    logic [31:0] seg_in = 32'h0;
    logic [7:0]  seg;
    logic [3:0]  an;
    logic        frame;

    int errors = 0;
    int checks = 0;
    bit chk_on = 1'b0;

    // Reference model: time since scan start plus buffer contents.
    bit          m_run   = 1'b0;
    int          m_t     = 0;
    logic [31:0] m_disp  = 32'h0;
    logic [31:0] m_pend  = 32'h0;
    bit          m_pflag = 1'b0;
    logic [7:0]  e_seg   = 8'h00;
    logic [3:0]  e_an    = 4'b1111;
    logic        e_frame = 1'b0;

    seg7_scan4 #(.PRESCALE(PS), .BLANK_CYC(BC)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .load   (load),
        .seg_in (seg_in),
        .seg    (seg),
        .an     (an),
        .frame  (frame)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] s, input logic [3:0] a, input logic f);
        checks++;
        if (seg !== s || an !== a || frame !== f) begin
            errors++;
            $display("FAIL %s: got seg=%h an=%b frame=%b, want seg=%h an=%b frame=%b",
                     name, seg, an, frame, s, a, f);
        end
    endtask

    task automatic model_reset();
        m_run   = 1'b0;
        m_t     = 0;
        m_disp  = 32'h0;
        m_pend  = 32'h0;
        m_pflag = 1'b0;
        e_seg   = 8'h00;
        e_an    = 4'b1111;
        e_frame = 1'b0;
    endtask

    task automatic model_step();
        int d;
        bit w;
        if (!en) begin
            m_run = 1'b0;
            if (load) begin
                m_disp  = seg_in;
                m_pflag = 1'b0;
            end
            e_seg   = 8'h00;
            e_an    = 4'b1111;
            e_frame = 1'b0;
        end else begin
            w = 1'b0;
            if (!m_run) begin
                m_run = 1'b1;
                m_t   = 0;
            end else begin
                w   = ((m_t % FRM) == FRM - 1);
                m_t = m_t + 1;
            end
            if (w) begin
                if (load) begin
                    m_disp  = seg_in;
                    m_pflag = 1'b0;
                end else if (m_pflag) begin
                    m_disp  = m_pend;
                    m_pflag = 1'b0;
                end
            end else if (load) begin
                m_pend  = seg_in;
                m_pflag = 1'b1;
            end
            d       = (m_t / SLOT) % 4;
            e_frame = w;
            e_seg   = m_disp[d*8 +: 8];
            e_an    = 4'b1111 ^ (4'b0001 << d);
`ifdef SEG7_SCAN_BLANK_EN
            if ((m_t % SLOT) < BLK) begin
                e_seg = 8'h00;
                e_an  = 4'b1111;
            end
`endif
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_step();
        end
    end

    // Cycle-by-cycle compare against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_on) check("model", e_seg, e_an, e_frame);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        cyc(2);
        rst_n  = 1'b1;
        chk_on = 1'b1;
        cyc(1);
        check("idle_blank", 8'h00, 4'b1111, 1'b0);

        seg_in = 32'hB6_66_F2_60;
        load   = 1'b1;
        cyc(1);
        load   = 1'b0;
        cyc(1);
        check("load_en_low_blank", 8'h00, 4'b1111, 1'b0);

        en = 1'b1;
        cyc(1);
        cyc(1);
        check("scan_d0", 8'h60, 4'b1110, 1'b0);
        cyc(4);
        check("scan_d1", 8'hF2, 4'b1101, 1'b0);
        cyc(4);
        check("scan_d2", 8'h66, 4'b1011, 1'b0);
        cyc(4);
        check("scan_d3", 8'hB6, 4'b0111, 1'b0);
        cyc(3);
`ifdef SEG7_SCAN_BLANK_EN
        check("frame_pulse", 8'h00, 4'b1111, 1'b1);
`else
        check("frame_pulse", 8'h60, 4'b1110, 1'b1);
`endif

        cyc(4);
        seg_in = 32'hFC_FC_FC_FC;
        load   = 1'b1;
        cyc(1);
        load   = 1'b0;
        cyc(4);
        check("dbuf_old_d2", 8'h66, 4'b1011, 1'b0);
        cyc(4);
        check("dbuf_old_d3", 8'hB6, 4'b0111, 1'b0);
        cyc(4);
        check("dbuf_new_d0", 8'hFC, 4'b1110, 1'b0);

        cyc(14);
        seg_in = 32'hE0_E0_E0_E0;
        load   = 1'b1;
        cyc(1);
        load   = 1'b0;
`ifdef SEG7_SCAN_BLANK_EN
        check("wrap_load_frame", 8'h00, 4'b1111, 1'b1);
`else
        check("wrap_load_frame", 8'hE0, 4'b1110, 1'b1);
`endif
        cyc(1);
        check("wrap_load_d0", 8'hE0, 4'b1110, 1'b0);
        cyc(16);
        check("wrap_load_no_stale", 8'hE0, 4'b1110, 1'b0);

        cyc(1);
        seg_in = 32'h3A_5B_7C_1D;
        load   = 1'b1;
        cyc(1);
        load   = 1'b0;
        cyc(3);
        seg_in = 32'h9E_8D_6F_07;
        load   = 1'b1;
        cyc(1);
        load   = 1'b0;
        cyc(10);
        check("overwrite_d0", 8'h07, 4'b1110, 1'b0);
        cyc(4);
        check("overwrite_d1", 8'h6F, 4'b1101, 1'b0);

        cyc(1);
        en = 1'b0;
        cyc(1);
        check("en_drop_blank", 8'h00, 4'b1111, 1'b0);
        seg_in = 32'h0D_25_9F_02;
        load   = 1'b1;
        cyc(1);
        load   = 1'b0;
        cyc(1);
        check("en_low_still_blank", 8'h00, 4'b1111, 1'b0);

        en = 1'b1;
        cyc(2);
        check("restart_d0", 8'h02, 4'b1110, 1'b0);
        cyc(2);
        check("restart_d0_hold", 8'h02, 4'b1110, 1'b0);
        cyc(1);
`ifdef SEG7_SCAN_BLANK_EN
        check("restart_d1_dead", 8'h00, 4'b1111, 1'b0);
`else
        check("restart_d1", 8'h9F, 4'b1101, 1'b0);
`endif
        cyc(3);

        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("reset_async", 8'h00, 4'b1111, 1'b0);
        cyc(2);
        en    = 1'b0;
        rst_n = 1'b1;
        cyc(2);
        check("reset_release_blank", 8'h00, 4'b1111, 1'b0);

        chk_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seg7_scan4.md
# seg7_scan4

Four-digit multiplexed 7-segment display scanner. It sits directly downstream of the team's counter/decoder stages and consumes their 8-bit segment patterns (bit 7 = a … bit 1 = g, bit 0 = dp, active-high). It time-multiplexes four patterns onto one shared segment bus with one-hot active-low digit enables. Updates are double-buffered so a new set of digits only becomes visible at a frame boundary, which prevents tearing.

## Interface
- PRESCALE, 16'd49999: prescaler terminal count; one digit slot lasts PRESCALE+1 cycles; legal range 1..65535.
- BLANK_CYC, 16'd4: dead-time cycles at the start of each slot. Used only with SEG7_SCAN_BLANK_EN; must be < PRESCALE.
- CLK  input  1  system clock, rising edge.
- RST_N  input  1  reset, asynchronous, active-low.
- EN  input  1  scan enable; low blanks the display and holds the scan at digit 0.
- LOAD  input  1  single-cycle strobe; captures SEG_IN.
- SEG_IN  input  32  four patterns; [7:0] = digit 0 … [31:24] = digit 3.
- SEG  output  8  segment drive, active-high.
- AN  output  4  digit enables, active-low, one-hot-low; AN[i] low selects digit i.
- FRAME  output  1  one-cycle pulse on every scan wrap from digit 3 to digit 0.

## Operation
- State: prescaler `pcnt` (16b), digit index `idx` (2b), display regs `disp[0..3]`, pending regs `pend[0..3]`, pending flag `pflag`.
- Reset (RST_N low, immediate): pcnt=0, idx=0, disp/pend=0, pflag=0, SEG=8'h00, AN=4'b1111, FRAME=0.
- EN high, prescaler behaviour:
  - pcnt counts 0..PRESCALE and wraps to 0.
  - `tick` = (pcnt==PRESCALE).
  - On tick, idx increments mod 4 (3→0 is a wrap).
- LOAD with EN high, no wrap in the same cycle: pend<=SEG_IN and pflag<=1. Repeated LOADs overwrite pend; the last one wins.
- Wrap tick:
  - If pflag=1: disp<=pend, pflag<=0.
  - FRAME<=1 for exactly one cycle.
- LOAD in the same cycle as a wrap tick: disp<=SEG_IN directly, pflag<=0. The new data is shown from digit 0 of the new frame.
- EN low:
  - pcnt<=0, idx<=0, FRAME=0, SEG=8'h00, AN=4'b1111.
  - LOAD writes disp directly and clears pflag.
- EN rising: scanning restarts at digit 0 with pcnt=0. The first slot lasts the full PRESCALE+1 cycles.
- SEG and AN are registers, loaded on the same edge as pcnt/idx. They reflect the new idx with no extra lag: SEG=disp[idx], AN=~(4'b0001<<idx).

## Timing
- Slot length: PRESCALE+1 cycles. Frame length: 4·(PRESCALE+1) cycles.
- FRAME is asserted in the first cycle of digit 0 (same edge as the idx 3→0 change).
- LOAD→visible latency:
  - Up to one frame: data appears at the next wrap.
  - 0 cycles of extra delay if LOAD coincides with the wrap.
  - 1 cycle if EN is low (disp written next edge).
- No combinational path from any input to any output.
- Reset deassertion is asynchronous to CLK; the first count occurs on the first rising edge with RST_N high.

## Configuration
- SEG7_SCAN_BLANK_EN defined:
  - While EN is high and pcnt<BLANK_CYC, SEG=8'h00 and AN=4'b1111 (anti-ghosting dead time).
  - The selected digit is driven for pcnt in BLANK_CYC..PRESCALE.
  - Slot length is unchanged.
- Undefined: no dead time; the digit is driven for all PRESCALE+1 cycles. BLANK_CYC is ignored and no comparator is synthesised.

## Test plan
All scenarios use PRESCALE=3 (4-cycle slots).
- Reset and idle:
  - RST_N low mid-scan → SEG=00, AN=1111, FRAME=0 with no clock edge.
  - Release with EN=0 → outputs stay blank.
- Scan sequence:
  - Stimulus: EN=1, LOAD with SEG_IN=32'hB6_66_F2_60 while EN=0.
  - Response: AN cycles 1110,1101,1011,0111 every 4 cycles; SEG cycles 60,F2,66,B6.
  - FRAME pulses once every 16 cycles, coincident with AN=1110.
- Double buffering:
  - Stimulus: during digit 1 of a frame, LOAD SEG_IN=32'hFC_FC_FC_FC.
  - Response: digits 2 and 3 still show the old values; SEG=FC from the next FRAME.
- Simultaneous LOAD and wrap:
  - Stimulus: LOAD 32'hE0_E0_E0_E0 on the wrap-tick cycle.
  - Response: digit 0 of the new frame shows E0, and pflag is 0 afterwards.
- Overwrite and disable:
  - Two LOADs in one frame → only the second appears.
  - EN dropped mid-slot → blank on the next edge.
  - EN re-raised → digit 0 is held for a full 4 cycles.
- Blank option (SEG7_SCAN_BLANK_EN, BLANK_CYC=1):
  - Each slot shows 1 cycle of AN=1111/SEG=00, then 3 cycles of the digit.
  - Without the macro, all 4 cycles show the digit.
